// File: rtl/uart_alu_bridge.sv
// UART-ALU bridge: pops an (A, B, opcode) frame from the RX FIFO, runs the ALU and pushes one result byte to the TX FIFO.
// Optional stall timeout in WAIT_B/WAIT_OP is enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_bridge #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned TO_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic [DBIT-1:0] tx_data,
    output logic            tx_wr,
    output logic            busy,
    output logic            err
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'h20);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'h22);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(6'h24);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'h25);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'h26);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'h27);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'h02);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [DBIT-1:0] a_q, a_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [DBIT-1:0] res_q, res_d;

    logic [DBIT-1:0] alu_res;
    logic            alu_ok;
    logic            shamt_big;

    // Upper opcode-byte bits carry no meaning.
    logic unused_op_hi;
    assign unused_op_hi = ^rx_data[DBIT-1:OP_W];

`ifdef UART_ALU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_to;
    assign unused_to = ^32'(TO_CYC);
`endif

    // Combinational ALU on the captured operands.
    always_comb begin
        alu_res   = '0;
        alu_ok    = 1'b1;
        shamt_big = (32'(b_q) >= DBIT);
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SRA:  alu_res = shamt_big ? {DBIT{a_q[DBIT-1]}}
                                         : DBIT'($signed(a_q) >>> b_q);
            OP_SRL:  alu_res = shamt_big ? '0 : (a_q >> b_q);
            default: alu_ok  = 1'b0;
        endcase
    end

    // Next-state and handshake logic; FIFO requests are suppressed while reset is held.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        rx_rd   = 1'b0;
        tx_wr   = 1'b0;
        err     = 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            WAIT_A: begin
                rx_rd = ~rx_empty & reset;
                if (!rx_empty) begin
                    a_d     = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                rx_rd = ~rx_empty & reset;
                if (!rx_empty) begin
                    b_d     = rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                rx_rd = ~rx_empty & reset;
                if (!rx_empty) begin
                    op_d    = rx_data[OP_W-1:0];
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = alu_ok ? alu_res : '0;
                err     = ~alu_ok;
                state_d = SEND;
            end
            SEND: begin
                tx_wr = ~tx_full & reset;
                if (!tx_full) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
`ifdef UART_ALU_TIMEOUT_EN
        // Stall watchdog for a frame that stops arriving part-way through.
        if ((state_q == WAIT_B || state_q == WAIT_OP) && rx_empty) begin
            if (cnt_q == CNT_MAX) begin
                err     = 1'b1;
                state_d = WAIT_A;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

`ifdef UART_ALU_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign tx_data = res_q;
    assign busy    = (state_q != WAIT_A);

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Directed bench for uart_alu_bridge with a queue-based RX FIFO and TX capture.
// Build with UART_ALU_TIMEOUT_EN to exercise the stall timeout (TO_CYC=16).
module tb_uart_alu_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       busy;
    logic       err;

    uart_alu_bridge #(.DBIT(8), .OP_W(6), .TO_CYC(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] out_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_rd = -1;
    int wr_cyc = 0;
    int prev_wr_cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int e0 = 0;
    logic prev_wr = 1'b0;
    logic busy_after_wr = 1'b1;
    logic s_rd, s_wr, s_busy, s_err;
    logic [7:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic mark();
        first_rd = -1;
        out_q.delete();
    endtask

    // One clock: sample at the falling edge, apply FIFO pops just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_rd   = rx_rd;
        s_wr   = tx_wr;
        s_busy = busy;
        s_err  = err;
        s_data = tx_data;
        chk("rd_while_empty", 32'(s_rd & rx_empty), 32'd0);
        chk("wr_while_full", 32'(s_wr & tx_full), 32'd0);
        chk("rd_wr_same_cycle", 32'(s_rd & s_wr), 32'd0);
        if (prev_wr) busy_after_wr = s_busy;
        prev_wr = s_wr;
        if (s_rd && first_rd < 0) first_rd = cyc;
        if (s_wr) begin
            out_q.push_back(s_data);
            prev_wr_cyc = wr_cyc;
            wr_cyc = cyc;
        end
        if (s_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        refresh();
        cyc++;
    endtask

    task automatic wait_out(input int n, input string tag);
        int budget;
        budget = 300;
        while (out_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_wait"}, 32'(out_q.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        tx_full = 1'b0;
        refresh();
        push(8'h55);

        // Reset state, with a byte visible to prove rx_rd stays low
        tick();
        chk("rst_rx_rd", 32'(s_rd), 32'd0);
        chk("rst_tx_wr", 32'(s_wr), 32'd0);
        chk("rst_tx_data", 32'(s_data), 32'h00);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        tick();
        rx_q.delete();
        refresh();
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(s_busy), 32'd0);

        // ADD with latency and busy fall
        mark();
        push(8'h05); push(8'h03); push(8'h20);
        wait_out(1, "t1");
        chk("t1_add", 32'(out_q[0]), 32'h08);
        chk("t1_latency", 32'(wr_cyc - first_rd), 32'd4);
        tick();
        chk("t1_busy_fall", 32'(busy_after_wr), 32'd0);
        chk("t1_no_err", 32'(err_cnt), 32'd0);

        // Back-to-back frames: SUB, SRA, SRL, SRA with large shift
        mark();
        push(8'h03); push(8'h05); push(8'h22);
        push(8'h80); push(8'h01); push(8'h03);
        push(8'h80); push(8'h01); push(8'h02);
        push(8'h80); push(8'h09); push(8'h03);
        wait_out(4, "t2");
        chk("t2_sub", 32'(out_q[0]), 32'hFE);
        chk("t2_sra1", 32'(out_q[1]), 32'hC0);
        chk("t2_srl1", 32'(out_q[2]), 32'h40);
        chk("t2_sra9", 32'(out_q[3]), 32'hFF);
        chk("t2_throughput", 32'(wr_cyc - prev_wr_cyc), 32'd5);

        // NOR with TX back-pressure held through SEND
        tx_full = 1'b1;
        mark();
        push(8'hF0); push(8'h0F); push(8'h27);
        repeat (16) tick();
        chk("t3_no_wr_full", 32'(out_q.size()), 32'd0);
        chk("t3_busy_stall", 32'(s_busy), 32'd1);
        chk("t3_data_stall", 32'(s_data), 32'h00);
        tx_full = 1'b0;
        wait_out(1, "t3");
        chk("t3_nor", 32'(out_q[0]), 32'h00);
        repeat (5) tick();
        chk("t3_single_wr", 32'(out_q.size()), 32'd1);

        // Invalid opcode, then recovery with AND
        e0 = err_cnt;
        mark();
        push(8'h12); push(8'h34); push(8'h3F);
        wait_out(1, "t4");
        chk("t4_bad_res", 32'(out_q[0]), 32'h00);
        chk("t4_err_pulse", 32'(err_cnt - e0), 32'd1);
        chk("t4_err_in_calc", 32'(wr_cyc - err_cyc), 32'd1);
        mark();
        push(8'h01); push(8'h01); push(8'h24);
        wait_out(1, "t4b");
        chk("t4_and", 32'(out_q[0]), 32'h01);
        chk("t4_no_new_err", 32'(err_cnt - e0), 32'd1);

        // Reset mid-frame discards the partial frame
        mark();
        push(8'h05); push(8'h03);
        repeat (3) tick();
        chk("t5_partial_popped", 32'(rx_q.size()), 32'd0);
        reset = 1'b0;
        push(8'h0A); push(8'h0B); push(8'h25);
        tick();
        chk("t5_rst_rd0", 32'(s_rd), 32'd0);
        chk("t5_rst_busy0", 32'(s_busy), 32'd0);
        tick();
        chk("t5_rst_rd1", 32'(s_rd), 32'd0);
        reset = 1'b1;
        wait_out(1, "t5");
        chk("t5_or", 32'(out_q[0]), 32'h0B);
        repeat (8) tick();
        chk("t5_single_res", 32'(out_q.size()), 32'd1);

`ifdef UART_ALU_TIMEOUT_EN
        // Partial frame times out after TO_CYC stalled cycles
        e0 = err_cnt;
        mark();
        push(8'h07);
        repeat (25) tick();
        chk("t6_to_err", 32'(err_cnt - e0), 32'd1);
        chk("t6_to_cycle", 32'(err_cyc - first_rd), 32'd16);
        chk("t6_idle", 32'(s_busy), 32'd0);
        mark();
        push(8'h02); push(8'h03); push(8'h20);
        wait_out(1, "t6");
        chk("t6_add", 32'(out_q[0]), 32'h05);
`else
        // Without the timeout a partial frame waits indefinitely
        e0 = err_cnt;
        mark();
        push(8'h07);
        repeat (40) tick();
        chk("t6_no_err", 32'(err_cnt - e0), 32'd0);
        chk("t6_still_busy", 32'(s_busy), 32'd1);
        push(8'h03); push(8'h20);
        wait_out(1, "t6");
        chk("t6_add", 32'(out_q[0]), 32'h0A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
